// File: rtl/bus_xfer_sched_pkg.sv
// Shared types for the register-to-register bus transfer scheduler.
// reg_op_t is the per-register bus control seen by the register file.
package bus_xfer_sched_pkg;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TURN = 2'd2
  } state_e;

endpackage

// File: rtl/bus_xfer_sched_if.sv
// Request handshake and register control bundle of bus_xfer_sched.
// master = requester/control side, slave = the scheduler.
interface bus_xfer_sched_if
  import bus_xfer_sched_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2
);
  localparam int RIDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int QIDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*RIDX_W-1:0] req_src;
  logic [NUM_REQ*RIDX_W-1:0] req_dst;
  logic [NUM_REQ-1:0]        req_ready;
  reg_op_t [NUM_REGS-1:0]    reg_op;
  logic                      busy;
  logic                      done;
  logic [QIDX_W-1:0]         done_id;
  logic                      err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, reg_op, busy, done, done_id, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, reg_op, busy, done, done_id, err
  );

endinterface

// File: rtl/bus_xfer_sched.sv
// Round-robin scheduler for register-to-register moves on the shared bus.
// Guarantees at most one bus driver and one latcher per cycle.
module bus_xfer_sched
  import bus_xfer_sched_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int NUM_REQ    = 2,
  parameter bit TURNAROUND = 1'b1
) (
  input logic            clk,
  input logic            rst,
  bus_xfer_sched_if.slave bus
);
  localparam int RIDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int QIDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [RIDX_W:0] NREG = (RIDX_W+1)'(NUM_REGS);

  state_e state_q, state_d;
  logic [QIDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [QIDX_W-1:0] id_q, id_d;
  logic [RIDX_W-1:0] src_q, src_d;
  logic [RIDX_W-1:0] dst_q, dst_d;

  logic [NUM_REQ-1:0] gnt;
  logic [QIDX_W-1:0]  gnt_id;
  logic               in_range;
  logic               xfer;
  reg_op_t [NUM_REGS-1:0] ops;

  // Scan from rr_ptr with wrap; first valid requester wins.
  always_comb begin : arb
    int  idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (state_q == S_IDLE && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && i == idx && bus.req_valid[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            gnt_id = QIDX_W'(i);
          end
        end
      end
    end
  end

  always_comb begin : fsm
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    src_d    = src_q;
    dst_d    = dst_q;
    unique case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          state_d = S_XFER;
          id_d    = gnt_id;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
              src_d = bus.req_src[i*RIDX_W +: RIDX_W];
              dst_d = bus.req_dst[i*RIDX_W +: RIDX_W];
            end
          end
          if (int'(gnt_id) == NUM_REQ - 1) rr_ptr_d = '0;
          else rr_ptr_d = gnt_id + 1'b1;
        end
      end
      S_XFER:  state_d = TURNAROUND ? S_TURN : S_IDLE;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign xfer     = (state_q == S_XFER);
  assign in_range = ({1'b0, src_q} < NREG) && ({1'b0, dst_q} < NREG);

  // Decode strictly from holding registers, never from req_*.
  always_comb begin : dec
    for (int i = 0; i < NUM_REGS; i++) ops[i] = REG_OP_NONE;
    if (xfer && in_range && src_q != dst_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RIDX_W'(i) == src_q) ops[i] = REG_OP_WRITE;
        else if (RIDX_W'(i) == dst_q) ops[i] = REG_OP_READ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.reg_op    = ops;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = xfer;
  assign bus.done_id   = xfer ? id_q : '0;
  assign bus.err       = xfer && !in_range;

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Directed bench for bus_xfer_sched: three instances cover
// TURNAROUND=1, a non-power-of-2 register count, and TURNAROUND=0.
module tb_bus_xfer_sched;
  import bus_xfer_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_xfer_sched_if #(.NUM_REGS(4), .NUM_REQ(2)) a_if ();
  bus_xfer_sched_if #(.NUM_REGS(3), .NUM_REQ(2)) b_if ();
  bus_xfer_sched_if #(.NUM_REGS(4), .NUM_REQ(2)) c_if ();

  bus_xfer_sched #(.NUM_REGS(4), .NUM_REQ(2), .TURNAROUND(1'b1)) u_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  bus_xfer_sched #(.NUM_REGS(3), .NUM_REQ(2), .TURNAROUND(1'b1)) u_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );
  bus_xfer_sched #(.NUM_REGS(4), .NUM_REQ(2), .TURNAROUND(1'b0)) u_c (
    .clk(clk), .rst(rst), .bus(c_if)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int nw;
    int nr;
    int exp_ops [2];
    exp_ops[0] = 'h06;
    exp_ops[1] = 'h60;

    a_if.req_valid = '0; a_if.req_src = '0; a_if.req_dst = '0;
    b_if.req_valid = '0; b_if.req_src = '0; b_if.req_dst = '0;
    c_if.req_valid = '0; c_if.req_src = '0; c_if.req_dst = '0;
    rst = 1'b1;
    step();
    step();

    // reset state
    check("rst_busy", int'(a_if.busy), 0);
    check("rst_done", int'(a_if.done), 0);
    check("rst_id", int'(a_if.done_id), 0);
    check("rst_err", int'(a_if.err), 0);
    check("rst_ops", int'(a_if.reg_op), 0);
    a_if.req_valid = 2'b11;
    #1 check("rst_ready", int'(a_if.req_ready), 0);
    a_if.req_valid = 2'b00;

    // single move req0 1 -> 2
    rst = 1'b0;
    a_if.req_src = {2'd0, 2'd1};
    a_if.req_dst = {2'd0, 2'd2};
    a_if.req_valid = 2'b01;
    #1 check("mv_ready", int'(a_if.req_ready), 1);
    step();
    check("mv_ops", int'(a_if.reg_op), 'h18);
    check("mv_done", int'(a_if.done), 1);
    check("mv_id", int'(a_if.done_id), 0);
    check("mv_err", int'(a_if.err), 0);
    check("mv_busy", int'(a_if.busy), 1);
    check("mv_rdy_x", int'(a_if.req_ready), 0);
    a_if.req_valid = 2'b00;
    step();
    check("turn_ops", int'(a_if.reg_op), 0);
    check("turn_busy", int'(a_if.busy), 1);
    check("turn_done", int'(a_if.done), 0);
    step();
    check("idle_busy", int'(a_if.busy), 0);

    // contention from reset: req0 0->1, req1 2->3
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_if.req_src = {2'd2, 2'd0};
    a_if.req_dst = {2'd3, 2'd1};
    a_if.req_valid = 2'b11;
    #1 check("ct_ready", int'(a_if.req_ready), 1);
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      nw = 0;
      nr = 0;
      for (int i = 0; i < 4; i++) begin
        if (a_if.reg_op[i] == REG_OP_WRITE) nw++;
        if (a_if.reg_op[i] == REG_OP_READ) nr++;
      end
      check("ct_one_wr", int'(nw <= 1), 1);
      check("ct_one_rd", int'(nr <= 1), 1);
      if (c % 3 == 1) begin
        check("ct_done", int'(a_if.done), 1);
        check("ct_id", int'(a_if.done_id), k % 2);
        check("ct_ops", int'(a_if.reg_op), exp_ops[k % 2]);
        k++;
      end else begin
        check("ct_nodone", int'(a_if.done), 0);
      end
    end
    check("ct_count", k, 4);
    a_if.req_valid = 2'b00;

    // same-register no-op
    a_if.req_src = {2'd0, 2'd3};
    a_if.req_dst = {2'd0, 2'd3};
    a_if.req_valid = 2'b01;
    #1 check("nop_ready", int'(a_if.req_ready), 1);
    step();
    check("nop_ops", int'(a_if.reg_op), 0);
    check("nop_done", int'(a_if.done), 1);
    check("nop_err", int'(a_if.err), 0);
    a_if.req_valid = 2'b00;
    step();
    step();

    // reset during XFER; rr_ptr was 1 before reset
    a_if.req_src = {2'd0, 2'd1};
    a_if.req_dst = {2'd0, 2'd0};
    a_if.req_valid = 2'b01;
    #1 check("mr_ready", int'(a_if.req_ready), 1);
    step();
    check("mr_ops", int'(a_if.reg_op), 'h09);
    check("mr_done", int'(a_if.done), 1);
    rst = 1'b1;
    a_if.req_valid = 2'b00;
    step();
    check("mr_busy", int'(a_if.busy), 0);
    check("mr_nodone", int'(a_if.done), 0);
    check("mr_id", int'(a_if.done_id), 0);
    check("mr_err", int'(a_if.err), 0);
    check("mr_ops0", int'(a_if.reg_op), 0);
    a_if.req_valid = 2'b11;
    #1 check("mr_rst_gate", int'(a_if.req_ready), 0);
    rst = 1'b0;
    #1 check("mr_rrptr", int'(a_if.req_ready), 1);
    step();
    check("mr_next_id", int'(a_if.done_id), 0);
    a_if.req_valid = 2'b00;
    step();
    step();

    // out of range on NUM_REGS=3
    b_if.req_src = {2'd0, 2'd0};
    b_if.req_dst = {2'd0, 2'd3};
    b_if.req_valid = 2'b01;
    #1 check("oor_ready", int'(b_if.req_ready), 1);
    step();
    check("oor_ops", int'(b_if.reg_op), 0);
    check("oor_done", int'(b_if.done), 1);
    check("oor_err", int'(b_if.err), 1);
    check("oor_busy", int'(b_if.busy), 1);
    b_if.req_valid = 2'b00;
    step();
    check("oor_err_end", int'(b_if.err), 0);
    step();
    b_if.req_src = {2'd0, 2'd2};
    b_if.req_dst = {2'd0, 2'd0};
    b_if.req_valid = 2'b01;
    #1 check("r3_ready", int'(b_if.req_ready), 1);
    step();
    check("r3_ops", int'(b_if.reg_op), 'h21);
    check("r3_err", int'(b_if.err), 0);
    b_if.req_valid = 2'b00;
    step();
    step();

    // TURNAROUND=0, req1 3->2 held valid
    c_if.req_src = {2'd3, 2'd0};
    c_if.req_dst = {2'd2, 2'd0};
    c_if.req_valid = 2'b10;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("bb_busy", int'(c_if.busy), c % 2);
      check("bb_done", int'(c_if.done), c % 2);
      check("bb_ready", int'(c_if.req_ready), (c % 2 == 0) ? 2 : 0);
      check("bb_ops", int'(c_if.reg_op), (c % 2 == 1) ? 'h90 : 0);
      if (c % 2 == 1) check("bb_id", int'(c_if.done_id), 1);
      step();
    end
    c_if.req_valid = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
